// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums a burst of unsigned products behind a
// valid/ready input and presents the registered total on a valid/ready output.
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clear,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  len_reg, len_next;
  logic              ovf_reg, ovf_next;
  logic [ACC_W-1:0]  out_acc_reg, out_acc_next;
  logic              out_ovf_reg, out_ovf_next;

  logic              in_xfer;
  logic              out_xfer;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W:0]    sum_ext;
  logic [CNT_W-1:0]  first_len;
  logic [CNT_W-1:0]  cnt_inc;

  assign in_ready  = ena & (state_reg != HOLD);
  assign out_valid = (state_reg == HOLD);
  assign busy      = (state_reg != IDLE);
  assign out_acc   = out_acc_reg;
  assign out_ovf   = out_ovf_reg;

  // ena gates both handshakes so nothing transfers while the tile is frozen
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready & ena;

  assign prod_ext  = ACC_W'(in_prod);
  assign sum_ext   = {1'b0, acc_reg} + {1'b0, prod_ext};
  assign first_len = (burst_len == '0) ? CNT_W'(1) : burst_len;
  assign cnt_inc   = cnt_reg + CNT_W'(1);

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    len_next     = len_reg;
    ovf_next     = ovf_reg;
    out_acc_next = out_acc_reg;
    out_ovf_next = out_ovf_reg;

    if (clear) begin
      state_next   = IDLE;
      acc_next     = '0;
      cnt_next     = '0;
      len_next     = '0;
      ovf_next     = 1'b0;
      out_acc_next = '0;
      out_ovf_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_xfer) begin
            len_next = first_len;
            acc_next = prod_ext;
            cnt_next = CNT_W'(1);
            ovf_next = 1'b0;
            if (first_len == CNT_W'(1)) begin
              state_next   = HOLD;
              out_acc_next = prod_ext;
              out_ovf_next = 1'b0;
            end else begin
              state_next = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            acc_next = sum_ext[ACC_W-1:0];
            ovf_next = ovf_reg | sum_ext[ACC_W];
            cnt_next = cnt_inc;
            // Result registers load on HOLD entry so the last product is included
            if (cnt_inc == len_reg) begin
              state_next   = HOLD;
              out_acc_next = sum_ext[ACC_W-1:0];
              out_ovf_next = ovf_reg | sum_ext[ACC_W];
            end
          end
        end
        HOLD: begin
          if (out_xfer) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      len_reg     <= '0;
      ovf_reg     <= 1'b0;
      out_acc_reg <= '0;
      out_ovf_reg <= 1'b0;
    end else if (ena) begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      len_reg     <= len_next;
      ovf_reg     <= ovf_next;
      out_acc_reg <= out_acc_next;
      out_ovf_reg <= out_ovf_next;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 16-bit and a 10-bit instance share
// stimulus; burst results are checked against a scoreboard on each output transfer.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clear;
  logic [3:0] burst_len;
  logic       in_valid;
  logic [7:0] in_prod;
  logic       out_ready;

  logic        in_ready16, out_valid16, out_ovf16, busy16;
  logic [15:0] out_acc16;
  logic        in_ready10, out_valid10, out_ovf10, busy10;
  logic [9:0]  out_acc10;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int pops   = 0;

  typedef struct {
    logic [15:0] a16;
    logic        o16;
    logic [9:0]  a10;
    logic        o10;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  product_accumulator u_dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .burst_len(burst_len),
    .in_valid(in_valid), .in_ready(in_ready16), .in_prod(in_prod),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
    .out_ovf(out_ovf16), .busy(busy16)
  );

  product_accumulator #(.ACC_W(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .burst_len(burst_len),
    .in_valid(in_valid), .in_ready(in_ready10), .in_prod(in_prod),
    .out_valid(out_valid10), .out_ready(out_ready), .out_acc(out_acc10),
    .out_ovf(out_ovf10), .busy(busy10)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Model: true sum reduced modulo each accumulator width, carry flag from the true sum
  task automatic expect_burst(input int sum);
    exp_t e;
    e.a16 = 16'(sum % 65536);
    e.o16 = (sum >= 65536);
    e.a10 = 10'(sum % 1024);
    e.o10 = (sum >= 1024);
    sb.push_back(e);
    pushes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p);
    in_valid = 1'b1;
    in_prod  = p;
    tick();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && ena && out_valid16 && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        check("sb_valid10", 32'(out_valid10), 32'd1);
        check("sb_acc16", 32'(out_acc16), 32'(e.a16));
        check("sb_ovf16", 32'(out_ovf16), 32'(e.o16));
        check("sb_acc10", 32'(out_acc10), 32'(e.a10));
        check("sb_ovf10", 32'(out_ovf10), 32'(e.o10));
        $display("burst %0d: acc16=%0h ovf16=%0b acc10=%0h ovf10=%0b",
                 pops, out_acc16, out_ovf16, out_acc10, out_ovf10);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; burst_len = 4'd0;
    in_valid = 1'b0; in_prod = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_acc", 32'(out_acc16), 32'd0);
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_out_ovf", 32'(out_ovf16), 32'd0);
    check("rst_busy", 32'(busy16), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready16), 32'd1);

    // Basic burst followed by back-pressure in HOLD
    burst_len = 4'd4;
    out_ready = 1'b0;
    expect_burst(4 * 225);
    repeat (4) send(8'hE1);
    check("basic_valid", 32'(out_valid16), 32'd1);
    check("basic_acc", 32'(out_acc16), 32'h0384);
    check("basic_ovf", 32'(out_ovf16), 32'd0);
    in_valid = 1'b1;
    in_prod  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_acc", 32'(out_acc16), 32'h0384);
      check("bp_in_ready", 32'(in_ready16), 32'd0);
      check("bp_valid", 32'(out_valid16), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid16), 32'd0);
    check("bp_release_in_ready", 32'(in_ready16), 32'd1);
    check("bp_release_busy", 32'(busy16), 32'd0);

    // Gapped input; burst_len change after the first product must be ignored
    burst_len = 4'd3;
    expect_burst(8'h10 + 8'h20 + 8'h30);
    send(8'h10);
    burst_len = 4'd1;
    tick();
    tick();
    send(8'h20);
    tick();
    send(8'h30);
    check("gap_valid", 32'(out_valid16), 32'd1);
    check("gap_acc", 32'(out_acc16), 32'h0060);
    tick();

    // burst_len of zero behaves as one
    burst_len = 4'd0;
    expect_burst(7);
    send(8'h07);
    check("len0_valid", 32'(out_valid16), 32'd1);
    check("len0_acc", 32'(out_acc16), 32'h0007);
    tick();

    // Overflow visible only on the 10-bit instance, then cleared by the next burst
    burst_len = 4'd5;
    expect_burst(5 * 225);
    repeat (5) send(8'hE1);
    check("ovf_acc10", 32'(out_acc10), 32'd101);
    check("ovf_flag10", 32'(out_ovf10), 32'd1);
    check("ovf_flag16", 32'(out_ovf16), 32'd0);
    tick();
    burst_len = 4'd1;
    expect_burst(1);
    send(8'h01);
    check("ovf_next_acc10", 32'(out_acc10), 32'd1);
    check("ovf_next_flag10", 32'(out_ovf10), 32'd0);
    tick();

    // clear after two of four products; the product presented with clear is dropped
    burst_len = 4'd4;
    send(8'h03);
    send(8'h04);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 8'h55;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_busy", 32'(busy16), 32'd0);
    check("clr_out_acc", 32'(out_acc16), 32'd0);
    check("clr_out_ovf", 32'(out_ovf16), 32'd0);
    check("clr_out_valid", 32'(out_valid16), 32'd0);
    check("clr_in_ready", 32'(in_ready16), 32'd1);
    burst_len = 4'd2;
    expect_burst(5 + 6);
    send(8'h05);
    send(8'h06);
    check("clr_fresh_acc", 32'(out_acc16), 32'h000B);
    tick();

    // ena low mid-burst with in_valid high: nothing counted, state frozen
    burst_len = 4'd3;
    expect_burst(8'h11 + 8'h22 + 8'h33);
    send(8'h11);
    ena      = 1'b0;
    in_valid = 1'b1;
    in_prod  = 8'h22;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ena_in_ready", 32'(in_ready16), 32'd0);
      check("ena_busy", 32'(busy16), 32'd1);
      check("ena_out_valid", 32'(out_valid16), 32'd0);
    end
    ena = 1'b1;
    send(8'h22);
    check("ena_mid_valid", 32'(out_valid16), 32'd0);
    send(8'h33);
    check("ena_valid", 32'(out_valid16), 32'd1);
    check("ena_acc", 32'(out_acc16), 32'h0066);
    tick();

    // Asynchronous reset between edges during ACCUM
    burst_len = 4'd4;
    send(8'h40);
    send(8'h41);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_acc", 32'(out_acc16), 32'd0);
    check("arst_out_valid", 32'(out_valid16), 32'd0);
    check("arst_busy", 32'(busy16), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("arst_in_ready", 32'(in_ready16), 32'd1);
    check("arst_busy_after", 32'(busy16), 32'd0);
    burst_len = 4'd1;
    expect_burst(9);
    send(8'h09);
    check("arst_next_acc", 32'(out_acc16), 32'h0009);
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("bursts_seen", 32'(pops), 32'(pushes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
